lsu_mem_sequencer: RTL

Load/store initiator that sits between the core's memory stage and the byte-addressed data memory (the memory's `Addr`/`Size`/`load_extend_sign`/`DataIn`/`DataOut`/`WEN` port set). It accepts one load or store per handshake and drives the memory interface for one or more cycles. Aligned accesses are issued as a single beat. Misaligned halfword and word accesses are either split into sequential byte beats with the load data reassembled and extended, or rejected, depending on a parameter.

---
 rtl/lsu_mem_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer between the memory stage and a byte-addressed data memory.
// Aligned accesses take one beat; misaligned ones are split into byte beats or rejected.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BEAT  | driving one memory beat per cycle, beat index idx_q
// RESP  | one-cycle response pulse, then back to IDLE
module lsu_mem_sequencer #(
    parameter logic SPLIT_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        split_q;
    logic        err_q;
    logic [1:0]  idx_q;
    logic [1:0]  last_q;
    logic [31:0] rdata_q;

    logic        misaligned;
    logic        accept;
    logic [31:0] wdata_sh;
    logic [31:0] load_result;

    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
    assign accept     = req_valid && (state_q == S_IDLE);
    assign wdata_sh   = wdata_q >> {idx_q, 3'b000};

    // Split halfword loads are extended here; aligned loads were already extended by the memory.
    always_comb begin
        load_result = rdata_q;
        if (split_q && (size_q == 2'b01)) begin
            load_result = {{16{sign_q & rdata_q[15]}}, rdata_q[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_addr   = 32'h0;
        mem_size   = 2'b00;
        mem_sign   = 1'b0;
        mem_wdata  = 32'h0;
        mem_wen    = 1'b1;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned && (SPLIT_EN == 1'b0)) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_BEAT;
                    end
                end
            end
            S_BEAT: begin
                mem_wen = ~write_q;
                if (split_q) begin
                    mem_addr  = addr_q + {30'h0, idx_q};
                    mem_wdata = {24'h0, wdata_sh[7:0]};
                end else begin
                    mem_addr  = addr_q;
                    mem_size  = size_q;
                    mem_sign  = sign_q;
                    mem_wdata = wdata_q;
                end
                if (idx_q == last_q) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!write_q && !err_q) begin
                    resp_rdata = load_result;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                sign_q  <= req_signed;
                write_q <= req_write;
                wdata_q <= req_wdata;
                split_q <= misaligned && (SPLIT_EN == 1'b1);
                err_q   <= misaligned && (SPLIT_EN == 1'b0);
                idx_q   <= 2'd0;
                rdata_q <= 32'h0;
                if (!misaligned) begin
                    last_q <= 2'd0;
                end else if (req_size == 2'b01) begin
                    last_q <= 2'd1;
                end else begin
                    last_q <= 2'd3;
                end
            end else if (state_q == S_BEAT) begin
                idx_q <= idx_q + 2'd1;
                if (!write_q) begin
                    if (split_q) begin
                        rdata_q[{idx_q, 3'b000} +: 8] <= mem_rdata[7:0];
                    end else begin
                        rdata_q <= mem_rdata;
                    end
                end
            end
        end
    end

endmodule
